instr_fetch_stage: RTL and testbench

//  Fetch stage directly upstream of decode/immediate extension: owns the PC, issues one

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/fetch_pc_reg.sv | 39 +++
 rtl/instr_fetch_stage.sv | 117 +++++++++++
 tb/tb_instr_fetch_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants: request FSM states, next-PC selector,
// canonical NOP encoding and default reset PC.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2,
        PC_TGT   = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter with next-PC selection: hold, sequential +4,
// immediate redirect target, or a redirect target saved while a fetch was in flight.
module fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_t         sel,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [XLEN-1:0] tgt,
    output logic [XLEN-1:0] pc_q
);

    logic [XLEN-1:0] pc_d;

    // Wraps modulo 2^XLEN; alignment of the low bits is not enforced.
    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            PC_HOLD:  pc_d = pc_q;
            PC_INC:   pc_d = pc_q + XLEN'(4);
            PC_REDIR: pc_d = redirect_pc;
            PC_TGT:   pc_d = tgt;
            default:  pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: one outstanding I-cache request at a time, a single-entry
// instruction buffer toward decode, and redirect handling that kills stale fetches.
module instr_fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            icache_req_o,
    output logic [XLEN-1:0] icache_addr_o,
    input  logic            icache_ready_i,
    input  logic [XLEN-1:0] icache_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    fetch_state_t    state_q, state_d;
    pc_sel_t         pc_sel;
    logic [XLEN-1:0] pc_q;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            valid_q, valid_d;
    logic            load_buf;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_buf_q;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .sel         (pc_sel),
        .redirect_pc (redirect_pc_i),
        .tgt         (tgt_q),
        .pc_q        (pc_q)
    );

    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        tgt_d    = tgt_q;
        valid_d  = valid_q;
        load_buf = 1'b0;
        pc_sel   = PC_HOLD;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_i) pc_sel = PC_REDIR;
            end
            REQ: begin
                if (icache_ready_i) begin
                    if (kill_q || redirect_i) begin
                        // Returning word belongs to the old path; restart from the newest target.
                        pc_sel  = redirect_i ? PC_REDIR : PC_TGT;
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        load_buf = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = FULL;
                    end
                end else if (redirect_i) begin
                    kill_d = 1'b1;
                    tgt_d  = redirect_pc_i;
                end
            end
            FULL: begin
                if (redirect_i) begin
                    valid_d = 1'b0;
                    pc_sel  = PC_REDIR;
                    state_d = REQ;
                end else if (dec_ready_i) begin
                    valid_d = 1'b0;
                    pc_sel  = PC_INC;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            kill_q   <= 1'b0;
            tgt_q    <= '0;
            valid_q  <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc_buf_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            if (load_buf) begin
                instr_q  <= icache_rdata_i[31:0];
                pc_buf_q <= pc_q;
            end
        end
    end

    assign icache_req_o  = (state_q == REQ);
    assign icache_addr_o = pc_q;
    assign dec_valid_o   = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_buf_q;
    assign pc_plus4_o    = pc_buf_q + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: a transaction-level model of the fetch
// buffer is compared every cycle, plus literal expectations at key points.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready = 1'b0;
    logic [31:0] icache_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int checks = 0;
    int errors = 0;

    instr_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .icache_req_o   (icache_req),
        .icache_addr_o  (icache_addr),
        .icache_ready_i (icache_ready),
        .icache_rdata_i (icache_rdata),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .dec_valid_o    (dec_valid),
        .dec_ready_i    (dec_ready),
        .instr_o        (instr),
        .pc_o           (pc),
        .pc_plus4_o     (pc_plus4)
    );

    always #5 clk = ~clk;

    // Model: a one-entry buffer, the address of the next fetch, a one-cycle
    // bubble after reset or a killed fetch, and a pending "fetch is stale" mark.
    bit          m_known = 0;
    bit          m_buf_valid;
    logic [31:0] m_buf_instr;
    logic [31:0] m_buf_pc;
    logic [31:0] m_fetch_pc;
    bit          m_bubble;
    bit          m_stale;
    logic [31:0] m_stale_tgt;

    task automatic model_step();
        if (rst) begin
            m_known     = 1;
            m_buf_valid = 0;
            m_buf_instr = 32'h0000_0013;
            m_buf_pc    = 32'h0;
            m_fetch_pc  = 32'h0;
            m_bubble    = 1;
            m_stale     = 0;
            m_stale_tgt = 32'h0;
        end else if (!m_known) begin
            // nothing defined before the first reset
        end else if (m_bubble) begin
            m_bubble = 0;
            if (redirect) m_fetch_pc = redirect_pc;
        end else if (m_buf_valid) begin
            if (redirect) begin
                m_buf_valid = 0;
                m_fetch_pc  = redirect_pc;
            end else if (dec_ready) begin
                m_buf_valid = 0;
                m_fetch_pc  = m_fetch_pc + 32'd4;
            end
        end else if (icache_ready) begin
            if (m_stale || redirect) begin
                m_fetch_pc = redirect ? redirect_pc : m_stale_tgt;
                m_stale    = 0;
                m_bubble   = 1;
            end else begin
                m_buf_valid = 1;
                m_buf_instr = icache_rdata;
                m_buf_pc    = m_fetch_pc;
            end
        end else if (redirect) begin
            m_stale     = 1;
            m_stale_tgt = redirect_pc;
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            cmp("model_req", {31'b0, icache_req}, {31'b0, !m_buf_valid && !m_bubble});
            cmp("model_valid", {31'b0, dec_valid}, {31'b0, m_buf_valid});
            if (!m_buf_valid && !m_bubble) cmp("model_addr", icache_addr, m_fetch_pc);
            if (m_buf_valid) begin
                cmp("model_instr", instr, m_buf_instr);
                cmp("model_pc", pc, m_buf_pc);
                cmp("model_pc_plus4", pc_plus4, m_buf_pc + 32'd4);
            end
        end
    end

    // Inputs change 2 time units after the edge; the model advances on the edge.
    task automatic step(input logic r, input logic rdy, input logic [31:0] rd,
                        input logic rdr, input logic [31:0] rp, input logic dr);
        rst          = r;
        icache_ready = rdy;
        icache_rdata = rd;
        redirect     = rdr;
        redirect_pc  = rp;
        dec_ready    = dr;
        @(posedge clk);
        model_step();
        #2;
    endtask

    localparam logic [31:0] ADDI = 32'h00A0_0093;

    initial begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        cmp("rst_req", {31'b0, icache_req}, 32'd0);
        cmp("rst_valid", {31'b0, dec_valid}, 32'd0);
        cmp("rst_instr", instr, 32'h0000_0013);
        cmp("rst_pc", pc, 32'h0);

        // Streaming with ready and consume every cycle
        step(0, 1, ADDI, 0, 0, 1);
        cmp("t1_addr0", icache_addr, 32'h0);
        cmp("t1_req0", {31'b0, icache_req}, 32'd1);
        step(0, 1, ADDI, 0, 0, 1);
        cmp("t1_instr", instr, ADDI);
        cmp("t1_pc0", pc, 32'h0);
        cmp("t1_pc_plus4", pc_plus4, 32'h4);
        step(0, 1, ADDI, 0, 0, 1);
        cmp("t1_addr1", icache_addr, 32'h4);
        step(0, 1, ADDI, 0, 0, 1);
        cmp("t1_pc1", pc, 32'h4);
        step(0, 1, ADDI, 0, 0, 1);
        cmp("t1_addr2", icache_addr, 32'h8);

        // Miss at 0x8: request held for five cycles
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 32'hBAD0_0000, 0, 0, 1);
            cmp("t2_req_held", {31'b0, icache_req}, 32'd1);
            cmp("t2_addr_held", icache_addr, 32'h8);
            cmp("t2_valid_low", {31'b0, dec_valid}, 32'd0);
        end
        step(0, 1, 32'h0030_0113, 0, 0, 0);
        cmp("t2_valid_rise", {31'b0, dec_valid}, 32'd1);
        cmp("t2_instr", instr, 32'h0030_0113);

        // Backpressure: buffer holds, no request, no PC advance
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
            cmp("t3_instr_hold", instr, 32'h0030_0113);
            cmp("t3_pc_hold", pc, 32'h8);
            cmp("t3_req_low", {31'b0, icache_req}, 32'd0);
        end
        step(0, 0, 0, 0, 0, 1);
        cmp("t3_addr_next", icache_addr, 32'hC);

        // Redirect under a pending miss; late word discarded
        step(0, 0, 0, 1, 32'h100, 0);
        cmp("t4_addr_stays", icache_addr, 32'hC);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        cmp("t4_valid_low", {31'b0, dec_valid}, 32'd0);
        cmp("t4_bubble_req", {31'b0, icache_req}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        cmp("t4_addr_redir", icache_addr, 32'h100);
        step(0, 1, 32'h0040_0193, 0, 0, 0);
        cmp("t4_pc", pc, 32'h100);

        // Redirect wins over consume in the full buffer
        step(0, 0, 0, 1, 32'h200, 1);
        cmp("t5_addr", icache_addr, 32'h200);
        cmp("t5_valid", {31'b0, dec_valid}, 32'd0);

        // Two redirects under a miss: the younger target is used
        step(0, 0, 0, 1, 32'h300, 0);
        step(0, 0, 0, 1, 32'h400, 0);
        step(0, 1, 32'h1111_1111, 0, 0, 0);
        step(0, 0, 0, 1, 32'h500, 0);
        cmp("t5_idle_redir", icache_addr, 32'h500);
        step(0, 0, 0, 1, 32'h600, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h2222_2222, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        cmp("t5_young_tgt", icache_addr, 32'h600);

        // Redirect coinciding with ready, then PC wrap
        step(0, 1, 32'h3333_3333, 1, 32'hFFFF_FFFC, 0);
        cmp("t6_discard", {31'b0, dec_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        cmp("t6_addr_top", icache_addr, 32'hFFFF_FFFC);
        step(0, 1, ADDI, 0, 0, 0);
        cmp("t6_pc_top", pc, 32'hFFFF_FFFC);
        cmp("t6_pc_plus4_wrap", pc_plus4, 32'h0);
        step(0, 0, 0, 0, 0, 1);
        cmp("t6_addr_wrap", icache_addr, 32'h0);

        // Reset while a request is outstanding
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h4444_4444, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        cmp("t6_addr_pre_rst", icache_addr, 32'h4);
        step(1, 0, 0, 0, 0, 0);
        cmp("t6_rst_req", {31'b0, icache_req}, 32'd0);
        cmp("t6_rst_instr", instr, 32'h0000_0013);
        cmp("t6_rst_valid", {31'b0, dec_valid}, 32'd0);
        step(0, 0, 0, 0, 0, 0);
        cmp("t6_restart_addr", icache_addr, 32'h0);
        cmp("t6_restart_req", {31'b0, icache_req}, 32'd1);
        step(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
